// File: rtl/dpram_port_master.sv
// dpram_port_master: burst initiator for a single dpram port.
// Accepts a burst command (start address, beats-1, direction) and issues the
// beats over the RAM valid/ready handshake. Write beats are pulled from the
// wr_* stream. Read results are returned on rd_* one cycle after each beat.
module dpram_port_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              ram_valid,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LEN_W:0]  CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    loaded_q;
  logic [LEN_W:0]    total_beats;
  logic              beat;
  logic              cmd_fire;
  logic              wr_fire;
  logic              all_loaded;
  logic              last_beat;

  // Handshake and burst-progress terms shared by the FSM and datapath.
  // Only one beat is ever in flight, so once every beat has been loaded the
  // next accepted beat is necessarily the last one.
  always_comb begin
    total_beats = {1'b0, len_q} + CNT_ONE;
    beat        = ram_valid && ram_ready;
    cmd_fire    = cmd_valid && cmd_ready;
    wr_fire     = wr_valid && wr_ready;
    all_loaded  = (loaded_q == total_beats);
    last_beat   = beat && all_loaded;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a burst ends when its final beat is accepted; reads
  // take one extra DRAIN cycle so the last rd_valid precedes done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = cmd_we ? WRITE : READ;
      WRITE:   if (last_beat) state_next = DONE;
      READ:    if (last_beat) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; cmd_ready is also held low while reset is asserted
  // and read data is only presented alongside rd_valid.
  always_comb begin
    cmd_ready = (state == IDLE) && rst_n;
    busy      = (state != IDLE);
    done      = (state == DONE);
    wr_ready  = (state == WRITE) && (!ram_valid || ram_ready) && !all_loaded;
    rd_data   = rd_valid ? ram_q : '0;
  end

  // Beat datapath: latches the command, loads the registered RAM request and
  // advances the wrapping address/beat count as beats are loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      loaded_q  <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_we    <= 1'b0;
      ram_valid <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= (state == READ) && beat;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            len_q    <= cmd_len;
            loaded_q <= '0;
            addr_q   <= cmd_addr;
            if (!cmd_we) begin
              ram_valid <= 1'b1;
              ram_we    <= 1'b0;
              ram_addr  <= cmd_addr;
              addr_q    <= cmd_addr + ADDR_ONE;
              loaded_q  <= CNT_ONE;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            ram_valid <= 1'b1;
            ram_we    <= 1'b1;
            ram_data  <= wr_data;
            ram_addr  <= addr_q;
            addr_q    <= addr_q + ADDR_ONE;
            loaded_q  <= loaded_q + CNT_ONE;
          end else if (beat) begin
            ram_valid <= 1'b0;
          end
        end
        READ: begin
          if (beat) begin
            if (all_loaded) begin
              ram_valid <= 1'b0;
            end else begin
              ram_addr <= addr_q;
              addr_q   <= addr_q + ADDR_ONE;
              loaded_q <= loaded_q + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_master.sv
// Directed testbench for dpram_port_master with a behavioural RAM model
// and a beat/rd_valid/done logger sampling on the rising clock edge.
module tb_dpram_port_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       ram_valid;
  logic       ram_ready;
  logic [7:0] ram_q;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
    logic       we;
  } beat_t;

  beat_t      beats[$];
  int         rdv_cyc[$];
  logic [7:0] rdv_data[$];
  int         done_cyc[$];
  int         cyc = 0;
  logic       wr_fire = 1'b0;
  logic [7:0] mem[256];
  logic [7:0] wr_src[$];
  int         wr_idx;
  bit         wr_gate;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  dpram_port_master #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_q(ram_q)
  );

  // RAM model: writes on a write beat, registered read data one cycle after a read beat.
  always @(posedge clk) begin
    if (ram_valid && ram_ready) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end

  // Logger: records beats, read results and done pulses with their edge index.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_valid && ram_ready) beats.push_back('{cyc, ram_addr, ram_data, ram_we});
    if (rd_valid) begin
      rdv_cyc.push_back(cyc);
      rdv_data.push_back(rd_data);
    end
    if (done) done_cyc.push_back(cyc);
    wr_fire <= wr_valid && wr_ready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveWr();
    wr_valid = wr_gate && (wr_idx < wr_src.size());
    wr_data  = wr_valid ? wr_src[wr_idx] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_fire) wr_idx++;
    driveWr();
  endtask

  task automatic loadWr(input logic [7:0] base, input int n);
    wr_src.delete();
    for (int i = 0; i < n; i++) wr_src.push_back(base + 8'(i));
    wr_idx  = 0;
    wr_gate = 1'b1;
    driveWr();
  endtask

  task automatic clearLogs();
    beats.delete();
    rdv_cyc.delete();
    rdv_data.delete();
    done_cyc.delete();
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_len   = 8'h00;
  endtask

  task automatic waitDone(input string tag, input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    checkOutput(tag, done, 1);
  endtask

  task automatic waitBeats(input string tag, input int want, input int max_cyc);
    int n = 0;
    while (beats.size() < want && n < max_cyc) begin
      tick();
      n++;
    end
    checkOutput(tag, beats.size(), want);
  endtask

  // Directed sequence covering reset, write/read bursts, stalls, wrap, gaps and mid-burst reset.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00;
    wr_gate = 1'b0; wr_idx = 0; ram_ready = 1'b1;
    driveWr();
    #3;
    checkOutput("rst_ram_valid", ram_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wr_ready", wr_ready, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_cmd_ready", cmd_ready, 1);

    $display("[TB] write burst 0x10 len 3");
    clearLogs();
    loadWr(8'hA0, 4);
    applyStimulus(1'b1, 8'h10, 8'd3);
    checkOutput("t1_busy", busy, 1);
    waitDone("t1_done", 20);
    tick();
    checkOutput("t1_nbeats", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checkOutput($sformatf("t1_addr%0d", i), beats[i].addr, 8'h10 + 8'(i));
      checkOutput($sformatf("t1_data%0d", i), beats[i].data, 8'hA0 + 8'(i));
      checkOutput($sformatf("t1_we%0d", i), beats[i].we, 1);
      checkOutput($sformatf("t1_cyc%0d", i), beats[i].cyc - beats[0].cyc, i);
    end
    checkOutput("t1_ndone", done_cyc.size(), 1);
    if (beats.size() == 4 && done_cyc.size() == 1)
      checkOutput("t1_done_lat", done_cyc[0] - beats[3].cyc, 1);
    checkOutput("t1_cmd_ready", cmd_ready, 1);
    checkOutput("t1_done_off", done, 0);

    $display("[TB] read burst 0x10 len 3");
    clearLogs();
    wr_gate = 1'b0; driveWr();
    applyStimulus(1'b0, 8'h10, 8'd3);
    checkOutput("t2_ram_valid", ram_valid, 1);
    waitDone("t2_done", 20);
    tick();
    checkOutput("t2_nbeats", beats.size(), 4);
    checkOutput("t2_nrd", rdv_data.size(), 4);
    for (int i = 0; i < 4 && i < beats.size() && i < rdv_data.size(); i++) begin
      checkOutput($sformatf("t2_we%0d", i), beats[i].we, 0);
      checkOutput($sformatf("t2_rd%0d", i), rdv_data[i], 8'hA0 + 8'(i));
      checkOutput($sformatf("t2_rdlat%0d", i), rdv_cyc[i] - beats[i].cyc, 1);
    end
    if (rdv_cyc.size() == 4 && done_cyc.size() == 1)
      checkOutput("t2_done_lat", done_cyc[0] - rdv_cyc[3], 1);

    $display("[TB] write burst with ram_ready stall");
    clearLogs();
    loadWr(8'hA0, 4);
    applyStimulus(1'b1, 8'h10, 8'd3);
    waitBeats("t3_first", 1, 10);
    ram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3_hold_v%0d", i), ram_valid, 1);
      checkOutput($sformatf("t3_hold_a%0d", i), ram_addr, 8'h11);
      checkOutput($sformatf("t3_hold_d%0d", i), ram_data, 8'hA1);
      tick();
    end
    ram_ready = 1'b1;
    waitDone("t3_done", 20);
    tick();
    checkOutput("t3_nbeats", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checkOutput($sformatf("t3_addr%0d", i), beats[i].addr, 8'h10 + 8'(i));
      checkOutput($sformatf("t3_data%0d", i), beats[i].data, 8'hA0 + 8'(i));
    end

    $display("[TB] read burst with address wrap");
    clearLogs();
    wr_gate = 1'b0; driveWr();
    applyStimulus(1'b0, 8'hFE, 8'd3);
    waitDone("t4_done", 20);
    tick();
    checkOutput("t4_nbeats", beats.size(), 4);
    if (beats.size() == 4) begin
      checkOutput("t4_addr0", beats[0].addr, 8'hFE);
      checkOutput("t4_addr1", beats[1].addr, 8'hFF);
      checkOutput("t4_addr2", beats[2].addr, 8'h00);
      checkOutput("t4_addr3", beats[3].addr, 8'h01);
    end
    checkOutput("t4_nrd", rdv_data.size(), 4);
    if (rdv_data.size() == 4) begin
      checkOutput("t4_rd0", rdv_data[0], 8'hA4);
      checkOutput("t4_rd1", rdv_data[1], 8'hA5);
      checkOutput("t4_rd2", rdv_data[2], 8'h5A);
      checkOutput("t4_rd3", rdv_data[3], 8'h5B);
    end

    $display("[TB] write burst with wr_valid gap and ignored command");
    clearLogs();
    loadWr(8'hB0, 3);
    applyStimulus(1'b1, 8'h30, 8'd2);
    for (int k = 0; k < 10 && wr_idx < 1; k++) tick();
    checkOutput("t5_first_load", wr_idx, 1);
    wr_gate = 1'b0; driveWr();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h99; cmd_len = 8'h00;
    checkOutput("t5_cmd_ready_busy", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("t5_gap1_valid", ram_valid, 0);
    checkOutput("t5_gap1_cmd_ready", cmd_ready, 0);
    tick();
    checkOutput("t5_gap2_valid", ram_valid, 0);
    checkOutput("t5_gap_beats", beats.size(), 1);
    wr_gate = 1'b1; driveWr();
    waitDone("t5_done", 20);
    tick();
    tick();
    tick();
    checkOutput("t5_nbeats", beats.size(), 3);
    for (int i = 0; i < 3 && i < beats.size(); i++) begin
      checkOutput($sformatf("t5_addr%0d", i), beats[i].addr, 8'h30 + 8'(i));
      checkOutput($sformatf("t5_data%0d", i), beats[i].data, 8'hB0 + 8'(i));
      checkOutput($sformatf("t5_we%0d", i), beats[i].we, 1);
    end
    checkOutput("t5_idle_busy", busy, 0);
    checkOutput("t5_idle_valid", ram_valid, 0);

    $display("[TB] reset during write burst, then single read");
    clearLogs();
    loadWr(8'hC0, 8);
    applyStimulus(1'b1, 8'h40, 8'd7);
    waitBeats("t6_two_beats", 2, 20);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ram_valid", ram_valid, 0);
    checkOutput("t6_rst_ram_we", ram_we, 0);
    checkOutput("t6_rst_ram_addr", ram_addr, 0);
    checkOutput("t6_rst_ram_data", ram_data, 0);
    checkOutput("t6_rst_wr_ready", wr_ready, 0);
    checkOutput("t6_rst_rd_valid", rd_valid, 0);
    checkOutput("t6_rst_rd_data", rd_data, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_done", done, 0);
    #1 rst_n = 1'b1;
    wr_gate = 1'b0; driveWr();
    #1;
    checkOutput("t6_rel_cmd_ready", cmd_ready, 1);
    tick();
    clearLogs();
    applyStimulus(1'b0, 8'h10, 8'd0);
    waitDone("t6_done", 20);
    tick();
    checkOutput("t6_nbeats", beats.size(), 1);
    if (beats.size() == 1) begin
      checkOutput("t6_addr", beats[0].addr, 8'h10);
      checkOutput("t6_we", beats[0].we, 0);
    end
    checkOutput("t6_nrd", rdv_data.size(), 1);
    if (rdv_data.size() == 1) checkOutput("t6_rd", rdv_data[0], 8'hA0);
    checkOutput("t6_cmd_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
